// File: rtl/amstrad_audio_mixer.sv
// Time-multiplexed stereo mixer for N unsigned PSG channels with per-channel pan/gain.
// Snapshots inputs on a strobe, accumulates one channel per clock, then saturates to the outputs.
module amstrad_audio_mixer #(
    parameter int CHANNELS = 3,
    parameter int IN_W     = 8,
    parameter int OUT_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_stb,
    input  logic [CHANNELS*IN_W-1:0] ch_in,
    input  logic                     pan_wr,
    input  logic [3:0]               pan_sel,
    input  logic [3:0]               pan_data,
    output logic [OUT_W-1:0]         audio_l,
    output logic [OUT_W-1:0]         audio_r,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int AW = IN_W + $clog2(CHANNELS) + 1;
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW = (AW > OUT_W) ? AW : OUT_W;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t              state, next_state;
    logic [IN_W-1:0]     snap [CHANNELS];
    logic [3:0]          pan  [CHANNELS];
    logic [AW-1:0]       acc_l, acc_r;
    logic [IW-1:0]       idx;
    logic                last_ch;
    logic [IN_W-1:0]     cur_sample, gain_l, gain_r;

    // Classic CPC stereo image: A left, B centre, C right, extras centred.
    function automatic logic [3:0] pan_default(input int k);
        case (k)
            0:       return 4'b1000;
            1:       return 4'b0101;
            2:       return 4'b0010;
            default: return 4'b0101;
        endcase
    endfunction

    function automatic logic [IN_W-1:0] apply_gain(input logic [1:0] code, input logic [IN_W-1:0] x);
        case (code)
            2'd0:    return '0;
            2'd1:    return x >> 2;
            2'd2:    return x >> 1;
            default: return x;
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] sat(input logic [AW-1:0] x);
        logic [SW-1:0] xe;
        xe = SW'(x);
        if (xe > SW'({OUT_W{1'b1}})) return '1;
        return xe[OUT_W-1:0];
    endfunction

    assign busy       = (state != IDLE);
    assign last_ch    = (idx == IW'(CHANNELS - 1));
    assign cur_sample = snap[idx];
    // Gains are looked up at accumulate time, so a pan write lands on any channel not yet summed.
    assign gain_l     = apply_gain(pan[idx][3:2], cur_sample);
    assign gain_r     = apply_gain(pan[idx][1:0], cur_sample);

    // NOTE: next_state is defaulted first so every path assigns it and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sample_stb) next_state = ACCUM;
            ACCUM:   if (last_ch)    next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: the snapshot is only read after being loaded, so it carries no reset; keeping it out
    // of the reset block avoids turning reset into a hold-enable on its flops.
    always_ff @(posedge clk) begin
        if (state == IDLE && sample_stb) begin
            for (int k = 0; k < CHANNELS; k++) snap[k] <= ch_in[k*IN_W +: IN_W];
        end
    end

    // NOTE: the pan file is reset because its defaults are architecturally visible after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) pan[k] <= pan_default(k);
            acc_l     <= '0;
            acc_r     <= '0;
            idx       <= '0;
            audio_l   <= '0;
            audio_r   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (pan_wr && pan_sel == 4'(k)) pan[k] <= pan_data;
            end
            out_valid <= 1'b0;
            if (sample_stb && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_stb) begin
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                    end
                end
                ACCUM: begin
                    acc_l <= acc_l + AW'(gain_l);
                    acc_r <= acc_r + AW'(gain_r);
                    idx   <= idx + 1'b1;
                end
                OUT: begin
                    audio_l   <= sat(acc_l);
                    audio_r   <= sat(acc_r);
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_amstrad_audio_mixer.sv
// Directed bench for amstrad_audio_mixer: 3-channel default build plus 9-channel 8- and 12-bit builds.
module tb_amstrad_audio_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_stb;
    logic [23:0] ch_in;
    logic        pan_wr;
    logic [3:0]  pan_sel, pan_data;
    logic [7:0]  audio_l, audio_r;
    logic        out_valid, busy, overrun;

    logic        stb9;
    logic [71:0] ch9;
    logic        pan_wr9;
    logic [3:0]  pan_sel9, pan_data9;
    logic [7:0]  l9, r9;
    logic [11:0] l9w, r9w;
    logic        v9, b9, o9, v9w, b9w, o9w;

    int n_checks = 0;
    int n_pass   = 0;
    int n_ov     = 0;

    always #5 clk = ~clk;

    amstrad_audio_mixer #(.CHANNELS(3), .IN_W(8), .OUT_W(8)) dut (
        .clk(clk), .reset(reset), .sample_stb(sample_stb), .ch_in(ch_in),
        .pan_wr(pan_wr), .pan_sel(pan_sel), .pan_data(pan_data),
        .audio_l(audio_l), .audio_r(audio_r), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    amstrad_audio_mixer #(.CHANNELS(9), .IN_W(8), .OUT_W(8)) dut9 (
        .clk(clk), .reset(reset), .sample_stb(stb9), .ch_in(ch9),
        .pan_wr(pan_wr9), .pan_sel(pan_sel9), .pan_data(pan_data9),
        .audio_l(l9), .audio_r(r9), .out_valid(v9), .busy(b9), .overrun(o9)
    );

    amstrad_audio_mixer #(.CHANNELS(9), .IN_W(8), .OUT_W(12)) dut9w (
        .clk(clk), .reset(reset), .sample_stb(stb9), .ch_in(ch9),
        .pan_wr(pan_wr9), .pan_sel(pan_sel9), .pan_data(pan_data9),
        .audio_l(l9w), .audio_r(r9w), .out_valid(v9w), .busy(b9w), .overrun(o9w)
    );

    always @(negedge clk) if (out_valid) n_ov++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pan_write(input logic [3:0] sel, input logic [3:0] data);
        pan_wr = 1'b1; pan_sel = sel; pan_data = data;
        tick();
        pan_wr = 1'b0;
    endtask

    // Ticks until out_valid is seen or the budget runs out; lat is edges after the strobe edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic mix3(output int lat);
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        wait_valid(lat);
    endtask

    initial begin
        int lat, ov0;
        logic [7:0] a, b, c, el, er;

        reset = 1'b1; sample_stb = 1'b0; ch_in = '0; pan_wr = 1'b0; pan_sel = '0; pan_data = '0;
        stb9 = 1'b0; ch9 = '0; pan_wr9 = 1'b0; pan_sel9 = '0; pan_data9 = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_audio_l", audio_l, 0);
        check("rst_audio_r", audio_r, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        // 1: default pans, all inputs full scale
        ch_in = {8'hFF, 8'hFF, 8'hFF};
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        check("t1_busy", busy, 1);
        wait_valid(lat);
        check("t1_latency", lat, 4);
        check("t1_l", audio_l, 190);
        check("t1_r", audio_r, 190);
        tick();
        check("t1_valid_pulse", out_valid, 0);
        check("t1_hold_l", audio_l, 190);

        // 2: reprogrammed pans
        pan_write(4'd0, 4'b1111);
        pan_write(4'd1, 4'b0000);
        pan_write(4'd2, 4'b0000);
        ch_in = {8'hFF, 8'hFF, 8'd200};
        mix3(lat);
        check("t2_full_l", audio_l, 200);
        check("t2_full_r", audio_r, 200);
        pan_write(4'd0, 4'b0101);
        ch_in = {8'hFF, 8'hFF, 8'd201};
        mix3(lat);
        check("t2_quarter_l", audio_l, 50);
        check("t2_quarter_r", audio_r, 50);
        pan_write(4'd0, 4'b1001);
        mix3(lat);
        check("t2_asym_l", audio_l, 100);
        check("t2_asym_r", audio_r, 50);

        // 3: nine channels, saturation vs. wide output
        for (int k = 0; k < 9; k++) begin
            pan_wr9 = 1'b1; pan_sel9 = 4'(k); pan_data9 = 4'b1111;
            tick();
        end
        pan_wr9 = 1'b0;
        ch9 = {72{1'b1}};
        stb9 = 1'b1;
        tick();
        stb9 = 1'b0;
        lat = 0;
        while (!v9 && lat < 30) begin
            tick();
            lat++;
        end
        check("t3_latency", lat, 10);
        check("t3_sat_l", l9, 255);
        check("t3_sat_r", r9, 255);
        check("t3_wide_valid", v9w, 1);
        check("t3_wide_l", l9w, 2295);
        check("t3_wide_r", r9w, 2295);

        // 4: snapshot coherence and overrun
        pan_write(4'd0, 4'b1111);
        pan_write(4'd1, 4'b1111);
        pan_write(4'd2, 4'b1111);
        check("t4_overrun_clear", overrun, 0);
        ov0 = n_ov;
        ch_in = {8'd30, 8'd20, 8'd10};
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        ch_in = {8'hFF, 8'hFF, 8'hFF};
        tick();
        ch_in = {8'd1, 8'd2, 8'd3};
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        ch_in = {8'd90, 8'd80, 8'd70};
        wait_valid(lat);
        check("t4_l", audio_l, 60);
        check("t4_r", audio_r, 60);
        repeat (8) tick();
        check("t4_one_valid", n_ov - ov0, 1);
        check("t4_overrun_sticky", overrun, 1);

        // 5: reset in the middle of a mix
        ov0 = n_ov;
        ch_in = {8'hFF, 8'hFF, 8'hFF};
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_l", audio_l, 0);
        check("t5_r", audio_r, 0);
        check("t5_overrun", overrun, 0);
        repeat (6) tick();
        check("t5_no_valid", n_ov - ov0, 0);
        mix3(lat);
        check("t5_latency", lat, 4);
        check("t5_default_l", audio_l, 190);
        check("t5_default_r", audio_r, 190);
        tick();

        // 6: back-to-back at the minimum period of CHANNELS+2
        ov0 = n_ov;
        for (int i = 0; i < 10; i++) begin
            a = 8'(16 * i + 3);
            b = 8'(8 * i + 100);
            c = 8'(255 - 12 * i);
            el = (a >> 1) + (b >> 2);
            er = (b >> 2) + (c >> 1);
            ch_in = {c, b, a};
            sample_stb = 1'b1;
            tick();
            sample_stb = 1'b0;
            ch_in = ~ch_in;
            repeat (4) tick();
            check($sformatf("t6_valid_%0d", i), out_valid, 1);
            check($sformatf("t6_l_%0d", i), audio_l, el);
            check($sformatf("t6_r_%0d", i), audio_r, er);
        end
        tick();
        check("t6_valid_count", n_ov - ov0, 10);
        check("t6_no_overrun", overrun, 0);

        // 7: strobe on the edge that raises out_valid is an overrun, not a new mix
        ov0 = n_ov;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        repeat (3) tick();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        check("t7_valid", out_valid, 1);
        check("t7_overrun", overrun, 1);
        tick();
        check("t7_not_restarted", busy, 0);
        repeat (6) tick();
        check("t7_valid_count", n_ov - ov0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
